// File: rtl/note_seq_pkg.sv
// Shared types for the note sequencer: FSM state codes and the table entry record.
package note_seq_pkg;

   localparam int NS_RATE_W = 16;
   localparam int NS_DUR_W  = 16;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_PLAY = 3'd2;
   localparam logic [2:0] S_GAP  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   typedef struct packed {
      logic [NS_RATE_W-1:0] rate;
      logic [NS_DUR_W-1:0]  dur;
   } note_entry_t;

endpackage

// File: rtl/note_seq_ctrl_ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 while enabled, one-cycle tick at wrap.
module ms_tick_gen #(
   parameter int TICK_DIV = 18432
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          wrap;

   assign wrap = (cnt_q == CW'(TICK_DIV - 1));
   assign tick = en && !clr && wrap;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)     cnt_d = '0;
      else if (en) cnt_d = wrap ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/note_seq_ctrl.sv
// Melody scheduler: steps a (rate, duration) table and drives the codec rate/mute
// controls, inserting a muted gap after each note.
module note_seq_ctrl
   import note_seq_pkg::*;
#(
   parameter int   NOTE_NUM     = 16,
   parameter int   RATE_W       = NS_RATE_W,
   parameter int   DUR_W        = NS_DUR_W,
   parameter int   TICK_DIV     = 18432,
   parameter int   GAP_MS       = 10,
   parameter int   DEFAULT_RATE = 48000,
   localparam int  AW           = $clog2(NOTE_NUM)
) (
   input  logic              iCLK_18_4,
   input  logic              iRST,
   input  logic              iWr_En,
   input  logic [AW-1:0]     iWr_Addr,
   input  logic [RATE_W-1:0] iWr_Rate,
   input  logic [DUR_W-1:0]  iWr_Dur,
   input  logic [AW:0]       iLen,
   input  logic              iStart,
   input  logic              iStop,
   input  logic              iLoop,
   output logic [RATE_W-1:0] oRate,
   output logic              oMute,
   output logic              oBusy,
   output logic              oDone,
   output logic [AW-1:0]     oNote_Idx
);

   note_entry_t tbl_q [NOTE_NUM];

   logic [2:0]        state_q, state_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic [AW:0]       len_q, len_d;
   logic [DUR_W-1:0]  dur_q, dur_d;
   logic [RATE_W-1:0] rate_q, rate_d;
   logic              mute_q, mute_d;
   logic              seg_end, tick, last;
   logic [AW:0]       nxt_idx;
   note_entry_t       ent;

   assign ent     = tbl_q[idx_q];
   assign nxt_idx = {1'b0, idx_q} + (AW+1)'(1);
   assign last    = (nxt_idx >= len_q);

   ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (iCLK_18_4),
      .rst  (iRST),
      .clr  (state_q == S_LOAD),
      .en   ((state_q == S_PLAY) || (state_q == S_GAP)),
      .tick (tick)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      dur_d   = dur_q;
      rate_d  = rate_q;
      mute_d  = mute_q;
      seg_end = 1'b0;
      case (state_q)
         S_IDLE: if (iStart && !iStop) begin
            if (iLen == '0) state_d = S_DONE;
            else begin
               len_d   = iLen;
               idx_d   = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (ent.dur == '0) state_d = S_DONE;
            else begin
               dur_d   = DUR_W'(ent.dur);
               state_d = S_PLAY;
               // A rest keeps the codec at its last rate; the codec is never given rate 0.
               if (ent.rate != '0) begin
                  rate_d = RATE_W'(ent.rate);
                  mute_d = 1'b0;
               end else mute_d = 1'b1;
            end
         end
         S_PLAY: if (tick) begin
            if (dur_q == DUR_W'(1)) begin
               mute_d = 1'b1;
               if (GAP_MS != 0) begin
                  state_d = S_GAP;
                  dur_d   = DUR_W'(GAP_MS);
               end else seg_end = 1'b1;
            end else dur_d = dur_q - DUR_W'(1);
         end
         S_GAP: if (tick) begin
            if (dur_q == DUR_W'(1)) seg_end = 1'b1;
            else                    dur_d   = dur_q - DUR_W'(1);
         end
         S_DONE: begin
            state_d = S_IDLE;
            mute_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      if (seg_end) begin
         if (!last) begin
            idx_d   = nxt_idx[AW-1:0];
            state_d = S_LOAD;
         end else if (iLoop) begin
            idx_d   = '0;
            state_d = S_LOAD;
         end else state_d = S_DONE;
      end

      // Abort wins over everything else and skips the done pulse.
      if (iStop && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         mute_d  = 1'b1;
         idx_d   = idx_q;
         rate_d  = rate_q;
      end
   end

   always_ff @(posedge iCLK_18_4) begin
      if (iRST) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         dur_q   <= '0;
         rate_q  <= RATE_W'(DEFAULT_RATE);
         mute_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         dur_q   <= dur_d;
         rate_q  <= rate_d;
         mute_q  <= mute_d;
      end
   end

   always_ff @(posedge iCLK_18_4) begin
      if (iWr_En && (state_q == S_IDLE))
         tbl_q[iWr_Addr] <= '{rate: NS_RATE_W'(iWr_Rate), dur: NS_DUR_W'(iWr_Dur)};
   end

   assign oRate     = rate_q;
   assign oMute     = mute_q;
   assign oBusy     = (state_q != S_IDLE);
   assign oDone     = (state_q == S_DONE);
   assign oNote_Idx = idx_q;

endmodule

// File: tb/tb_note_seq_ctrl.sv
// Scoreboard bench for note_seq_ctrl: expected per-cycle output trace is built from
// the note list and pushed at start; a negedge monitor pops and compares.
module tb_note_seq_ctrl;

   localparam int TD  = 4;
   localparam int GAP = 1;
   localparam int DEF = 48000;

   typedef struct packed {
      logic [15:0] rate;
      logic        mute;
      logic        busy;
      logic        done;
      logic [3:0]  idx;
   } snap_t;

   logic        clk = 1'b0;
   logic        iRST = 1'b1;
   logic        iWr_En = 1'b0;
   logic [3:0]  iWr_Addr = '0;
   logic [15:0] iWr_Rate = '0;
   logic [15:0] iWr_Dur = '0;
   logic [4:0]  iLen = '0;
   logic        iStart = 1'b0, iStop = 1'b0, iLoop = 1'b0;
   logic [15:0] oRate;
   logic        oMute, oBusy, oDone;
   logic [3:0]  oNote_Idx;

   always #5 clk = ~clk;

   note_seq_ctrl #(
      .NOTE_NUM(16), .RATE_W(16), .DUR_W(16),
      .TICK_DIV(TD), .GAP_MS(GAP), .DEFAULT_RATE(DEF)
   ) dut (
      .iCLK_18_4(clk), .iRST(iRST), .iWr_En(iWr_En), .iWr_Addr(iWr_Addr),
      .iWr_Rate(iWr_Rate), .iWr_Dur(iWr_Dur), .iLen(iLen), .iStart(iStart),
      .iStop(iStop), .iLoop(iLoop), .oRate(oRate), .oMute(oMute), .oBusy(oBusy),
      .oDone(oDone), .oNote_Idx(oNote_Idx)
   );

   snap_t       exp_q[$];
   int          total = 0, bad = 0;
   int unsigned t_rate[16], t_dur[16];
   logic [15:0] m_rate = 16'(DEF);
   logic [3:0]  m_idx = '0;
   snap_t       last_s;
   int          t_idx, abort_at;
   bit          aborted, abort_rst;

   always @(negedge clk) begin : mon
      snap_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if ({oRate, oMute, oBusy, oDone, oNote_Idx} !== {e.rate, e.mute, e.busy, e.done, e.idx}) begin
            bad++;
            $display("FAIL snap t=%0t: got rate=%0d mute=%0b busy=%0b done=%0b idx=%0d want rate=%0d mute=%0b busy=%0b done=%0b idx=%0d",
                     $time, oRate, oMute, oBusy, oDone, oNote_Idx, e.rate, e.mute, e.busy, e.done, e.idx);
         end
      end
   end

   task automatic emit(input logic [15:0] r, input logic mu, input logic bu, input logic dn, input logic [3:0] ix);
      snap_t s;
      if (aborted) return;
      if (t_idx == abort_at) begin
         if (abort_rst) s = '{16'(DEF), 1'b1, 1'b0, 1'b0, 4'd0};
         else           s = '{last_s.rate, 1'b1, 1'b0, 1'b0, last_s.idx};
         aborted = 1'b1;
      end else s = '{r, mu, bu, dn, ix};
      exp_q.push_back(s);
      last_s = s;
      t_idx++;
   endtask

   task automatic wr(input int a, input int unsigned r, input int unsigned d);
      @(posedge clk); #1;
      iWr_En = 1'b1; iWr_Addr = 4'(a); iWr_Rate = 16'(r); iWr_Dur = 16'(d);
      @(posedge clk); #1;
      iWr_En = 1'b0;
      t_rate[a] = r; t_dur[a] = d;
   endtask

   // ab_at: index of the post-start sample at which stop/reset lands (-1 = none)
   task automatic play(input int len, input bit lp, input int ab_at, input bit ab_rst, input bit wr_busy);
      snap_t       pre;
      int          i, c;
      logic [15:0] r;
      logic        mu;
      @(posedge clk); #1;
      t_idx = 0; aborted = 1'b0; abort_at = ab_at; abort_rst = ab_rst;
      pre = '{m_rate, 1'b1, 1'b0, 1'b0, m_idx};
      exp_q.push_back(pre);
      last_s = pre;
      if (len == 0) begin
         emit(m_rate, 1, 1, 1, m_idx);
         emit(m_rate, 1, 0, 0, m_idx);
      end else begin
         i = 0; r = m_rate;
         while (!aborted && t_idx < 3000) begin
            emit(r, 1, 1, 0, 4'(i));
            if (t_dur[i] == 0) begin
               emit(r, 1, 1, 1, 4'(i));
               emit(r, 1, 0, 0, 4'(i));
               break;
            end
            if (t_rate[i] != 0) r = 16'(t_rate[i]);
            mu = (t_rate[i] == 0);
            repeat (t_dur[i] * TD) emit(r, mu, 1, 0, 4'(i));
            repeat (GAP * TD) emit(r, 1, 1, 0, 4'(i));
            if (i + 1 < len) i++;
            else if (lp) i = 0;
            else begin
               emit(r, 1, 1, 1, 4'(i));
               emit(r, 1, 0, 0, 4'(i));
               break;
            end
         end
      end
      m_rate = last_s.rate;
      m_idx  = last_s.idx;

      iLen = 5'(len); iLoop = lp; iStart = 1'b1;
      @(posedge clk); #1;
      iStart = 1'b0;
      for (c = 1; c < 4000; c++) begin
         iStop    = !ab_rst && (c == ab_at);
         iRST     = ab_rst && (c == ab_at);
         iWr_En   = wr_busy && (c == 3);
         iWr_Addr = '0; iWr_Rate = 16'hBEEF; iWr_Dur = 16'd9;
         @(posedge clk); #1;
         if (exp_q.size() == 0) break;
      end
      iStop = 1'b0; iRST = 1'b0; iWr_En = 1'b0; iLoop = 1'b0;
      if (exp_q.size() != 0) begin
         total++; bad++;
         $display("FAIL timeout: %0d expected samples left, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      int ln, ab, n;
      bit lp;
      iRST = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      exp_q.push_back('{16'(DEF), 1'b1, 1'b0, 1'b0, 4'd0});
      @(posedge clk); #1;
      iRST = 1'b0;
      for (int a = 0; a < 16; a++) wr(a, 1000 + a, 1);

      // rest note: muted, default rate held
      wr(0, 0, 3);
      play(1, 0, -1, 0, 0);
      // two-note melody
      wr(0, 8000, 2); wr(1, 16000, 1);
      play(2, 0, -1, 0, 0);
      // loop a single note, write while busy (ignored), stop mid-play
      wr(0, 8000, 1);
      play(1, 1, 20, 0, 1);
      // empty sequence
      play(0, 0, -1, 0, 0);
      // zero duration ends early; entry0 must still be {8000,1}
      wr(1, 16000, 0); wr(2, 500, 2);
      play(3, 0, -1, 0, 0);
      // start and stop together while idle
      @(posedge clk); #1;
      repeat (3) exp_q.push_back('{m_rate, 1'b1, 1'b0, 1'b0, m_idx});
      iStart = 1'b1; iStop = 1'b1; iLen = 5'd2;
      @(posedge clk); #1;
      iStart = 1'b0; iStop = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      // reset during play, then replay from retained table
      wr(0, 8000, 2); wr(1, 16000, 1);
      play(2, 0, 5, 1, 0);
      play(2, 0, -1, 0, 0);

      for (int k = 0; k < 25; k++) begin
         n = $urandom_range(1, 3);
         for (int w = 0; w < n; w++)
            wr($urandom_range(0, 5), ($urandom % 4 == 0) ? 0 : $urandom_range(1, 65535),
               ($urandom % 8 == 0) ? 0 : $urandom_range(1, 3));
         ln = $urandom_range(0, 5);
         lp = ($urandom % 3 == 0);
         ab = lp ? $urandom_range(1, 80) : (($urandom % 4 == 0) ? $urandom_range(1, 40) : -1);
         play(ln, lp, ab, 0, 0);
      end

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
